// File: rtl/fm_modulate_if.sv
// FIFO-side signal bundle of the FM modulator: audio read port plus the I and Q
// write ports. The modulator is the master of all three FIFO handshakes.
interface fm_modulate_if;
    logic        in_rd_en;
    logic        in_empty;
    logic [31:0] in_dout;
    logic        real_wr_en;
    logic        real_full;
    logic [31:0] real_din;
    logic        imag_wr_en;
    logic        imag_full;
    logic [31:0] imag_din;

    modport master (
        output in_rd_en,
        input  in_empty,
        input  in_dout,
        output real_wr_en,
        input  real_full,
        output real_din,
        output imag_wr_en,
        input  imag_full,
        output imag_din
    );

    modport slave (
        input  in_rd_en,
        output in_empty,
        output in_dout,
        input  real_wr_en,
        output real_full,
        input  real_din,
        input  imag_wr_en,
        output imag_full,
        input  imag_din
    );
endinterface

// File: rtl/fm_modulate.sv
// FM modulator: accumulates gain*audio into a wrapping phase word and emits
// exp(j*phase) as an I/Q pair through a quarter-wave sine ROM.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_READ  | wait for audio; on pop, advance phase by gain*sample
//   S_LOOK  | fold registered phase through ROM, register I and Q
//   S_WRITE | push I and Q together once both FIFOs have room
module fm_modulate #(
    parameter int QUANT_BITS  = 10,
    parameter int PHASE_BITS  = 16,
    parameter int LUT_BITS    = 8,
    parameter int FM_MOD_GAIN = 16384
) (
    input  logic          clock,
    input  logic          reset,
    fm_modulate_if.master bus
);

    localparam int N = 1 << LUT_BITS;
    localparam int TW = QUANT_BITS + 1;   // ROM entry width, holds 0..2**QUANT_BITS
    localparam int SW = QUANT_BITS + 2;   // signed folded sample width

    localparam logic [LUT_BITS:0]    N_IDX  = (LUT_BITS + 1)'(N);
    localparam logic signed [63:0]   GAIN64 = 64'(FM_MOD_GAIN);
    localparam logic signed [63:0]   BIAS64 = 64'((1 << QUANT_BITS) - 1);

    // pi/2 in Q30
    localparam longint PI_HALF_Q30 = 64'd1686629713;

    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_LOOK  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // round(2**QUANT_BITS * sin(pi/2 * k/N)) using a Q30 Taylor series; the
    // fixed-point error is far below the rounding step, so entries are exact.
    function automatic logic [TW-1:0] sin_entry(input int k);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint r;
        x    = (PI_HALF_Q30 * longint'(k)) / longint'(N);
        x2   = (x * x) / (64'sd1 <<< 30);
        term = x;
        sum  = x;
        for (int n = 1; n <= 8; n++) begin
            term = (term * x2) / (64'sd1 <<< 30);
            term = -(term / longint'((2 * n) * (2 * n + 1)));
            sum  = sum + term;
        end
        r = (sum * (64'sd1 <<< QUANT_BITS) + (64'sd1 <<< 29)) >>> 30;
        return r[TW-1:0];
    endfunction

    logic [TW-1:0] rom_t [0:N];

    for (genvar k = 0; k <= N; k++) begin : g_rom
        assign rom_t[k] = sin_entry(k);
    end

    state_t                 state_q, state_d;
    logic [PHASE_BITS-1:0]  phase_q, phase_d;
    logic [31:0]            iout_q, iout_d;
    logic [31:0]            qout_q, qout_d;

    // Phase increment: gain*sample / 2**QUANT_BITS truncated toward zero.
    // Negative products are biased by 2**QUANT_BITS-1 before the arithmetic
    // shift so the shift rounds toward zero instead of toward -inf.
    logic signed [63:0]     din_s;
    logic signed [63:0]     prod;
    logic signed [63:0]     prod_b;
    logic [PHASE_BITS-1:0]  inc;

    assign din_s  = 64'(signed'(bus.in_dout));
    assign prod   = GAIN64 * din_s;
    assign prod_b = prod + (prod[63] ? BIAS64 : 64'sd0);
    assign inc    = PHASE_BITS'(prod_b >>> QUANT_BITS);

    // Quadrant fold of the registered phase into sin/cos.
    logic [1:0]            quad;
    logic [LUT_BITS-1:0]   addr;
    logic signed [SW-1:0]  t_a;
    logic signed [SW-1:0]  t_na;
    logic signed [SW-1:0]  sin_v;
    logic signed [SW-1:0]  cos_v;

    assign quad = phase_q[PHASE_BITS-1 -: 2];
    assign addr = phase_q[PHASE_BITS-3 -: LUT_BITS];
    assign t_a  = $signed({1'b0, rom_t[{1'b0, addr}]});
    assign t_na = $signed({1'b0, rom_t[N_IDX - {1'b0, addr}]});

    // sin/cos from the quarter-wave table by quadrant symmetry
    always_comb begin
        sin_v = t_a;
        cos_v = t_na;
        case (quad)
            2'd0: begin sin_v =  t_a;  cos_v =  t_na; end
            2'd1: begin sin_v =  t_na; cos_v = -t_a;  end
            2'd2: begin sin_v = -t_a;  cos_v = -t_na; end
            2'd3: begin sin_v = -t_na; cos_v =  t_a;  end
            default: begin sin_v = t_a; cos_v = t_na; end
        endcase
    end

    // Next state, datapath updates and FIFO strobes, all decoded from state.
    // Strobes are held low during reset so nothing is popped or pushed then.
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        iout_d         = iout_q;
        qout_d         = qout_q;
        bus.in_rd_en   = 1'b0;
        bus.real_wr_en = 1'b0;
        bus.imag_wr_en = 1'b0;
        bus.real_din   = 32'd0;
        bus.imag_din   = 32'd0;
        if (!reset) begin
            case (state_q)
                S_READ: begin
                    if (!bus.in_empty) begin
                        bus.in_rd_en = 1'b1;
                        phase_d      = phase_q + inc;
                        state_d      = S_LOOK;
                    end
                end
                S_LOOK: begin
                    iout_d  = 32'(cos_v);
                    qout_d  = 32'(sin_v);
                    state_d = S_WRITE;
                end
                S_WRITE: begin
                    // both FIFOs must accept; I and Q are never pushed apart
                    if (!bus.real_full && !bus.imag_full) begin
                        bus.real_wr_en = 1'b1;
                        bus.imag_wr_en = 1'b1;
                        bus.real_din   = iout_q;
                        bus.imag_din   = qout_q;
                        state_d        = S_READ;
                    end
                end
                default: state_d = S_READ;
            endcase
        end
    end

    // State and datapath registers; reset drops any in-flight sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_READ;
            phase_q <= '0;
            iout_q  <= '0;
            qout_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            iout_q  <= iout_d;
            qout_q  <= qout_d;
        end
    end

endmodule

// File: tb/tb_fm_modulate.sv
// Scoreboard bench for fm_modulate: stimulus pushes audio into a source FIFO
// model and the expected I/Q pair into a queue; a monitor pops on every write.
module tb_fm_modulate;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    fm_modulate_if bus ();

    fm_modulate dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int i;
        int q;
        int tol;
    } pair_t;

    pair_t exp_q [$];
    int    src_q [$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit f_real    = 1'b0;
    bit f_imag    = 1'b0;
    bit rnd_empty = 1'b0;
    bit rnd_full  = 1'b0;
    bit chk_space = 1'b0;
    bit wr_seen   = 1'b0;

    int wr_count = 0;
    int rd_count = 0;
    int last_rd  = -100;
    int last_wr  = -100;

    int rom_m [0:256];
    int m_phase = 0;

    always @(posedge clock) cyc++;

    // Audio FIFO and I/Q FIFO models: pop on the edge the DUT saw rd_en,
    // then update flags 1 time unit later, away from the sampling edge.
    always @(posedge clock) begin
        bit pop;
        pop = (bus.in_rd_en === 1'b1) && (bus.in_empty === 1'b0);
        #1;
        if (pop && src_q.size() > 0) void'(src_q.pop_front());
        bus.in_empty  = (src_q.size() == 0) || (rnd_empty && $urandom_range(0, 2) == 0);
        bus.in_dout   = (src_q.size() > 0) ? src_q[0] : 32'd0;
        bus.real_full = f_real || (rnd_full && $urandom_range(0, 2) == 0);
        bus.imag_full = f_imag || (rnd_full && $urandom_range(0, 2) == 0);
    end

    // Monitor: check every write against the scoreboard head.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.in_rd_en === 1'b1) begin
                rd_count++;
                last_rd = cyc;
            end
            if (bus.real_wr_en !== 1'b0 || bus.imag_wr_en !== 1'b0) begin
                int ai;
                int aq;
                wr_count++;
                checks++;
                if (bus.real_wr_en !== bus.imag_wr_en) begin
                    errors++;
                    $display("FAIL wr_pair real_wr_en=%b imag_wr_en=%b required equal", bus.real_wr_en, bus.imag_wr_en);
                end
                checks++;
                if (bus.real_full || bus.imag_full) begin
                    errors++;
                    $display("FAIL wr_while_full real_full=%b imag_full=%b required both 0", bus.real_full, bus.imag_full);
                end
                checks++;
                if (cyc - last_rd < 2) begin
                    errors++;
                    $display("FAIL latency got %0d cycles after rd_en required >= 2", cyc - last_rd);
                end
                if (chk_space && wr_seen) begin
                    checks++;
                    if (cyc - last_wr != 3) begin
                        errors++;
                        $display("FAIL spacing got %0d cycles required 3", cyc - last_wr);
                    end
                end
                wr_seen = 1'b1;
                last_wr = cyc;
                ai = $signed(bus.real_din);
                aq = $signed(bus.imag_din);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got (%0d,%0d) required no write", ai, aq);
                end else begin
                    pair_t e;
                    e = exp_q.pop_front();
                    if ($isunknown(bus.real_din) || $isunknown(bus.imag_din) ||
                        (ai - e.i > e.tol) || (e.i - ai > e.tol) ||
                        (aq - e.q > e.tol) || (e.q - aq > e.tol)) begin
                        errors++;
                        $display("FAIL iq got (%0d,%0d) required (%0d,%0d) tol %0d", ai, aq, e.i, e.q, e.tol);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (bus.in_rd_en !== 1'b0 || bus.real_wr_en !== 1'b0 || bus.imag_wr_en !== 1'b0 ||
            bus.real_din !== 32'd0 || bus.imag_din !== 32'd0) begin
            errors++;
            $display("FAIL %s rd=%b wr=%b/%b din=%h/%h required all 0", name, bus.in_rd_en,
                     bus.real_wr_en, bus.imag_wr_en, bus.real_din, bus.imag_din);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        f_real    = 1'b0;
        f_imag    = 1'b0;
        rnd_empty = 1'b0;
        rnd_full  = 1'b0;
        src_q.delete();
        exp_q.delete();
        tick(3);
        check_idle_outputs("reset_state");
        m_phase = 0;
        reset   = 1'b0;
        tick(1);
    endtask

    task automatic send(input int s, input int ei, input int eq, input int tol);
        pair_t e;
        e.i = ei;
        e.q = eq;
        e.tol = tol;
        src_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && n < limit) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || src_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending_out=%0d pending_in=%0d required 0/0", name, exp_q.size(), src_q.size());
        end
        tick(2);
    endtask

    task automatic wait_rd(input string name);
        int n;
        n = 0;
        while (bus.in_rd_en !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        checks++;
        if (bus.in_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL %s_rd_timeout in_rd_en=%b required 1", name, bus.in_rd_en);
        end
    endtask

    // Independent reference: 64-bit product, SV signed division, real-valued ROM.
    task automatic model_pair(input int s, output int ei, output int eq);
        longint p;
        longint d;
        int qd;
        int a;
        int sv;
        int cv;
        p = 64'sd16384 * longint'(s);
        d = p / 64'sd1024;
        m_phase = int'((longint'(m_phase) + d) & 64'sd65535);
        qd = m_phase / 16384;
        a  = (m_phase / 64) % 256;
        case (qd)
            0:       begin sv =  rom_m[a];       cv =  rom_m[256 - a]; end
            1:       begin sv =  rom_m[256 - a]; cv = -rom_m[a];       end
            2:       begin sv = -rom_m[a];       cv = -rom_m[256 - a]; end
            default: begin sv = -rom_m[256 - a]; cv =  rom_m[a];       end
        endcase
        ei = cv;
        eq = sv;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int w0;
        for (int k = 0; k <= 256; k++)
            rom_m[k] = $rtoi(1024.0 * $sin(3.14159265358979323846 * real'(k) / 512.0) + 0.5);

        do_reset();

        // zeros: phase never moves, writes every third cycle
        chk_space = 1'b1;
        wr_seen   = 1'b0;
        for (int n = 0; n < 3; n++) send(0, 1024, 0, 0);
        drain("zeros", 40);
        chk_space = 1'b0;

        // quarter-turn steps, wrapping through 65536
        do_reset();
        send(1024, 0, 1024, 0);
        send(1024, -1024, 0, 0);
        send(1024, 0, -1024, 0);
        send(1024, 1024, 0, 0);
        send(1024, 0, 1024, 0);
        drain("quarter", 60);

        // negative increment then eighth turn
        do_reset();
        send(-1024, 0, -1024, 0);
        send(512, 724, -724, 1);
        drain("negative", 40);

        // backpressure on the I FIFO, then on the Q FIFO
        do_reset();
        f_real = 1'b1;
        send(1024, 0, 1024, 0);
        send(1024, -1024, 0, 0);
        wait_rd("bp_real");
        tick(2);
        r0 = rd_count;
        w0 = wr_count;
        tick(10);
        checks++;
        if (wr_count != w0 || rd_count != r0) begin
            errors++;
            $display("FAIL bp_real_hold writes=%0d reads=%0d required 0/0", wr_count - w0, rd_count - r0);
        end
        f_real = 1'b0;
        drain("bp_real", 40);

        f_imag = 1'b1;
        send(1024, 0, -1024, 0);
        wait_rd("bp_imag");
        tick(2);
        r0 = rd_count;
        w0 = wr_count;
        src_q.push_back(0);
        tick(10);
        checks++;
        if (wr_count != w0 || rd_count != r0) begin
            errors++;
            $display("FAIL bp_imag_hold writes=%0d reads=%0d required 0/0", wr_count - w0, rd_count - r0);
        end
        f_imag = 1'b0;
        exp_q.push_back(pair_t'{0, -1024, 0});
        drain("bp_imag", 40);

        // reset in S_LOOK discards the sample and clears phase
        do_reset();
        src_q.push_back(1024);
        wait_rd("midreset");
        tick(1);
        reset = 1'b1;
        #1;
        check_idle_outputs("midreset_outputs");
        tick(2);
        reset = 1'b0;
        w0 = wr_count;
        tick(8);
        checks++;
        if (wr_count != w0) begin
            errors++;
            $display("FAIL midreset_nowrite writes=%0d required 0", wr_count - w0);
        end
        send(0, 1024, 0, 0);
        drain("midreset", 40);

        // random stream with random empty/full against the reference model
        do_reset();
        rnd_empty = 1'b1;
        rnd_full  = 1'b1;
        w0 = wr_count;
        for (int n = 0; n < 200; n++) begin
            int s;
            int ei;
            int eq;
            if (n % 16 == 15) s = int'($urandom());
            else              s = int'($urandom_range(0, 8191)) - 4096;
            model_pair(s, ei, eq);
            send(s, ei, eq, 0);
        end
        drain("random", 8000);
        checks++;
        if (wr_count - w0 != 200) begin
            errors++;
            $display("FAIL random_count got %0d writes required 200", wr_count - w0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
